// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: bundles the three buses of the MEM stage.
//   req_*  : EX -> stage request, valid/ready handshake
//   resp_* : stage -> WB result, valid/ready handshake
//   dmem_* : stage -> byte-addressed data memory (combinational read data)
// Modports:
//   slave  : the MEM stage itself
//   master : the surrounding pipeline / memory (EX, WB, data memory)
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [4:0]        resp_rd;
    logic              resp_is_load;
    logic              resp_fault;

    logic [ADDR_W-1:0] dmem_address;
    logic              dmem_read_write;
    logic [1:0]        dmem_access_size;
    logic [31:0]       dmem_data_in;
    logic [31:0]       dmem_data_out;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_rdata, resp_rd, resp_is_load, resp_fault,
        input  resp_ready,
        output dmem_address, dmem_read_write, dmem_access_size, dmem_data_in,
        input  dmem_data_out
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_rd, resp_is_load, resp_fault,
        output resp_ready,
        input  dmem_address, dmem_read_write, dmem_access_size, dmem_data_in,
        output dmem_data_out
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage between EX and a byte-addressed data
// memory. Accepts one load/store, drives the memory port for one ACCESS
// cycle, extends load data and holds the result in the MEM/WB register until
// writeback takes it. Saturating load/store counters for perf debug.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : req_* / resp_* handshakes and dmem_* memory port
//   load_count   : completed non-faulting loads, saturating
//   store_count  : completed non-faulting stores, saturating
// Options:
//   MEM_ACCESS_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses
//   fault like an illegal funct3; otherwise they proceed byte-wise.
// Note: ADDR_W must match the ADDR_W of the connected interface instance.
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_stage_if.slave bus,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              is_store;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [4:0]        rd;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic        accept;
    logic        illegal;
    logic        misalign;
    logic        fault;
    logic [31:0] load_data;

    logic [31:0] resp_rdata_q;
    logic [4:0]  resp_rd_q;
    logic        resp_is_load_q;
    logic        resp_fault_q;

    // A new request can enter while the old result retires in the same edge.
    assign bus.req_ready = (state == IDLE) || (state == RESP && bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        illegal = 1'b0;
        if (req_q.is_store) begin
            illegal = (req_q.funct3 > 3'b010);
        end else begin
            case (req_q.funct3)
                3'b011, 3'b110, 3'b111: illegal = 1'b1;
                default:                illegal = 1'b0;
            endcase
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (req_q.funct3[1:0])
            2'b01:   misalign = req_q.addr[0];
            2'b10:   misalign = (req_q.addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign fault = illegal || misalign;

    // Memory already returns data starting at addr, so no lane shifting.
    always_comb begin
        load_data = 32'd0;
        case (req_q.funct3)
            3'b000:  load_data = {{24{bus.dmem_data_out[7]}}, bus.dmem_data_out[7:0]};
            3'b001:  load_data = {{16{bus.dmem_data_out[15]}}, bus.dmem_data_out[15:0]};
            3'b010:  load_data = bus.dmem_data_out;
            3'b100:  load_data = {24'd0, bus.dmem_data_out[7:0]};
            3'b101:  load_data = {16'd0, bus.dmem_data_out[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // Address/size/data come straight from the request register, so they hold
    // their last value outside ACCESS. The write strobe is gated by rst_n so a
    // reset during ACCESS kills the pending store before the committing edge.
    assign bus.dmem_address     = req_q.addr;
    assign bus.dmem_access_size = req_q.funct3[1:0];
    assign bus.dmem_data_in     = req_q.wdata;
    assign bus.dmem_read_write  = rst_n && (state == ACCESS) && req_q.is_store && !fault;

    assign bus.resp_valid   = (state == RESP);
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_rd      = resp_rd_q;
    assign bus.resp_is_load = resp_is_load_q;
    assign bus.resp_fault   = resp_fault_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP: begin
                if (accept)              state_nxt = ACCESS;
                else if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q          <= '0;
            resp_rdata_q   <= 32'd0;
            resp_rd_q      <= 5'd0;
            resp_is_load_q <= 1'b0;
            resp_fault_q   <= 1'b0;
            load_count     <= '0;
            store_count    <= '0;
        end else begin
            if (accept) begin
                req_q <= '{is_store: bus.req_is_store, funct3: bus.req_funct3,
                           addr: bus.req_addr, wdata: bus.req_wdata, rd: bus.req_rd};
            end
            if (state == ACCESS) begin
                resp_rdata_q   <= (!req_q.is_store && !fault) ? load_data : 32'd0;
                resp_rd_q      <= req_q.is_store ? 5'd0 : req_q.rd;
                resp_is_load_q <= !req_q.is_store;
                resp_fault_q   <= fault;
                if (!fault) begin
                    if (req_q.is_store) begin
                        if (store_count != {CNT_W{1'b1}}) store_count <= store_count + 1'b1;
                    end else begin
                        if (load_count != {CNT_W{1'b1}}) load_count <= load_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: self-checking bench for mem_access_stage. A byte-array
// memory sits on the dmem port; a reference model with its own shadow memory
// predicts every response from the load/store rules. A directed vector table,
// hand-written reset/backpressure sequences and a random phase drive the DUT.
module tb_mem_access_stage;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CNT_W-1:0] load_count, store_count;

    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .load_count(load_count), .store_count(store_count)
    );

    // ---------------- data memory (4 KB window, wraps) ----------------
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [11:0] ma;
    int          wr_pulses = 0;

    assign ma = bus.dmem_address[11:0];
    assign bus.dmem_data_out = {mem[ma+12'd3], mem[ma+12'd2], mem[ma+12'd1], mem[ma]};

    always @(posedge clk) begin
        if (bus.dmem_read_write === 1'b1) begin
            for (int i = 0; i < 4; i++)
                if (i < (1 << bus.dmem_access_size)) mem[ma + i[11:0]] <= bus.dmem_data_in[8*i +: 8];
        end
    end

    always @(negedge clk) if (bus.dmem_read_write === 1'b1) wr_pulses++;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no req_ready within 20 cycles, want req_ready=1", nm);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_rdata;
    logic        m_fault;
    int          m_wr;
    int          m_lc = 0;
    int          m_sc = 0;

    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        bit          legal;
        int          nb;
        logic [31:0] w;
        logic [11:0] b;
        nb    = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if ((nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00)) legal = 0;
`endif
        b       = a[11:0];
        m_rdata = 32'd0;
        m_fault = !legal;
        m_wr    = 0;
        if (legal && st) begin
            for (int i = 0; i < nb; i++) ref_mem[b + i[11:0]] = wd[8*i +: 8];
            m_wr = 1;
            if (m_sc < CNT_MAX) m_sc++;
        end else if (legal) begin
            w = {ref_mem[b+12'd3], ref_mem[b+12'd2], ref_mem[b+12'd1], ref_mem[b]};
            case (f3)
                3'd0:    m_rdata = 32'($signed(w[7:0]));
                3'd1:    m_rdata = 32'($signed(w[15:0]));
                3'd2:    m_rdata = w;
                3'd4:    m_rdata = 32'(w[7:0]);
                default: m_rdata = 32'(w[15:0]);
            endcase
            if (m_lc < CNT_MAX) m_lc++;
        end
    endtask

    // ---------------- transaction helpers ----------------
    task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] rd);
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        bus.req_valid    = 1'b1;
    endtask

    // Called at the accept edge; leaves the result held (ends at a negedge).
    task automatic after_accept(input string nm, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [4:0] rd, input int hold, input int w0);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        model(st, f3, a, wd);
        @(negedge clk);
        chk({nm, " resp_valid in ACCESS"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        chk({nm, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({nm, " rdata"}, bus.resp_rdata, m_rdata);
        chk({nm, " fault"}, 32'(bus.resp_fault), 32'(m_fault));
        chk({nm, " rd"}, 32'(bus.resp_rd), st ? 32'd0 : 32'(rd));
        chk({nm, " is_load"}, 32'(bus.resp_is_load), 32'(!st));
        chk({nm, " writes"}, 32'(wr_pulses - w0), 32'(m_wr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " held req_ready"}, 32'(bus.req_ready), 32'd0);
            chk({nm, " held resp_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({nm, " held rdata"}, bus.resp_rdata, m_rdata);
            chk({nm, " held fault"}, 32'(bus.resp_fault), 32'(m_fault));
        end
    endtask

    task automatic retire();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic wait_ready(input string nm, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            fail_timeout(nm);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic xact(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int hold);
        bit ok;
        int w0;
        drive_req(st, f3, a, wd, rd);
        wait_ready(nm, ok);
        if (!ok) return;
        w0 = wr_pulses;
        @(posedge clk);
        after_accept(nm, st, f3, a, wd, rd, hold, w0);
        retire();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] er, logic ef);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.exp_rdata = er; v.exp_fault = ef;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2 ms");
        $fatal(1);
    end

    initial begin
        bit ok;
        int w0;
        logic [31:0] ra;

        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.req_valid = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h0100_0010;
        bus.req_wdata = 32'h1234_5678;
        bus.req_rd = 5'd1;
        bus.resp_ready = 1'b0;

        tbl.push_back(mk(1, 3'd2, 32'h0100_0010, 32'hDEADBEEF, 32'h0, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0010, 32'h0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 3'd2, 32'h0100_0020, 32'h000080F0, 32'h0, 0));
        tbl.push_back(mk(0, 3'd0, 32'h0100_0020, 32'h0, 32'hFFFFFFF0, 0));
        tbl.push_back(mk(0, 3'd4, 32'h0100_0020, 32'h0, 32'h000000F0, 0));
        tbl.push_back(mk(0, 3'd1, 32'h0100_0020, 32'h0, 32'hFFFF80F0, 0));
        tbl.push_back(mk(0, 3'd5, 32'h0100_0020, 32'h0, 32'h000080F0, 0));
        tbl.push_back(mk(0, 3'd3, 32'h0100_0020, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 3'd6, 32'h0100_0020, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 3'd7, 32'h0100_0020, 32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 3'd3, 32'h0100_0040, 32'h11111111, 32'h0, 1));
        tbl.push_back(mk(1, 3'd4, 32'h0100_0040, 32'h22222222, 32'h0, 1));
        tbl.push_back(mk(0, 3'd0, 32'h0100_0013, 32'h0, 32'hFFFFFFDE, 0));
        tbl.push_back(mk(1, 3'd0, 32'h0100_0011, 32'h00000055, 32'h0, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0010, 32'h0, 32'hDEAD55EF, 0));
        tbl.push_back(mk(1, 3'd1, 32'h0100_0014, 32'h1234ABCD, 32'h0, 0));
        tbl.push_back(mk(0, 3'd5, 32'h0100_0014, 32'h0, 32'h0000ABCD, 0));
        tbl.push_back(mk(1, 3'd2, 32'h0100_0030, 32'hCAFEF00D, 32'h0, 0));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        tbl.push_back(mk(1, 3'd2, 32'h0100_0002, 32'hA1B2C3D4, 32'h0, 1));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0000, 32'h0, 32'h00000000, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0004, 32'h0, 32'h00000000, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0012, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 3'd1, 32'h0100_0021, 32'h0, 32'h0, 1));
`else
        tbl.push_back(mk(1, 3'd2, 32'h0100_0002, 32'hA1B2C3D4, 32'h0, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0000, 32'h0, 32'hC3D40000, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0004, 32'h0, 32'h0000A1B2, 0));
        tbl.push_back(mk(0, 3'd2, 32'h0100_0012, 32'h0, 32'hABCDDEAD, 0));
        tbl.push_back(mk(0, 3'd1, 32'h0100_0021, 32'h0, 32'h00000080, 0));
`endif

        // ---- reset with req_valid held high ----
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset dmem_read_write", 32'(bus.dmem_read_write), 32'd0);
            chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        chk("reset resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset resp_rd", 32'(bus.resp_rd), 32'd0);
        chk("reset resp_is_load", 32'(bus.resp_is_load), 32'd0);
        chk("reset resp_fault", 32'(bus.resp_fault), 32'd0);
        chk("reset load_count", 32'(load_count), 32'd0);
        chk("reset store_count", 32'(store_count), 32'd0);
        chk("reset writes", 32'(wr_pulses), 32'd0);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---- table-driven directed vectors ----
        foreach (tbl[i]) begin
            xact($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                 5'(i + 1), 0);
            chk($sformatf("vec%0d table rdata", i), bus.resp_rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d table fault", i), 32'(bus.resp_fault), 32'(tbl[i].exp_fault));
        end
        chk("table load_count", 32'(load_count), 32'(m_lc));
        chk("table store_count", 32'(store_count), 32'(m_sc));

        // ---- reset during the ACCESS cycle of a store ----
        drive_req(1'b1, 3'd2, 32'h0100_0030, 32'h11223344, 5'd3);
        wait_ready("rst-mid-store", ok);
        if (ok) begin
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            chk("rst-mid-store dmem_read_write", 32'(bus.dmem_read_write), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("rst-mid-store resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("rst-mid-store load_count", 32'(load_count), 32'd0);
            chk("rst-mid-store store_count", 32'(store_count), 32'd0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            m_lc = 0;
            m_sc = 0;
        end
        xact("rst-mid-store readback", 1'b0, 3'd2, 32'h0100_0030, 32'h0, 5'd4, 0);
        chk("rst-mid-store word", bus.resp_rdata, 32'hCAFEF00D);

        // ---- backpressure then back-to-back accept ----
        drive_req(1'b0, 3'd2, 32'h0100_0010, 32'h0, 5'd7);
        wait_ready("bp first", ok);
        if (ok) begin
            w0 = wr_pulses;
            @(posedge clk);
            after_accept("bp first", 1'b0, 3'd2, 32'h0100_0010, 32'h0, 5'd7, 4, w0);
            drive_req(1'b1, 3'd1, 32'h0100_0050, 32'h0000BEEF, 5'd8);
            bus.resp_ready = 1'b1;
            #1;
            chk("b2b req_ready", 32'(bus.req_ready), 32'd1);
            w0 = wr_pulses;
            @(posedge clk);
            after_accept("b2b second", 1'b1, 3'd1, 32'h0100_0050, 32'h0000BEEF, 5'd8, 0, w0);
            retire();
        end

        // ---- random stimulus against the reference model ----
        for (int n = 0; n < 150; n++) begin
            ra = 32'h0100_0000 + 32'($urandom_range(0, 255));
            xact($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ra, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end
        chk("final load_count", 32'(load_count), 32'(m_lc));
        chk("final store_count", 32'(store_count), 32'(m_sc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
